// File: rtl/reg_bank_rd.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_rd
// Description : Register bank for the multicycle MIPS datapath. It holds
//               32 x 32-bit registers that are written from the write-data
//               mux output. The bank is read through two registered ports
//               (A = rs, B = rt) that feed the A/B operand latches.
//               - r0 is hardwired to zero.
//               - r[SP_ADDR] ($sp) resets to SP_INIT.
//               - A read is a req/valid handshake with one cycle of latency.
//               - Reset is asynchronous and active-high.
// Build option: REG_BANK_BYPASS_EN
//               When defined, a read that hits the register being written in
//               the same cycle returns the new data (write-before-read).
//               The check is done independently on each port. When undefined,
//               such a read returns the old register contents.
// Ports       : clk        in   rising-edge clock
//               reset      in   asynchronous active-high reset
//               reg_wr     in   write enable
//               wr_addr    in   write register index
//               wr_data    in   write data
//               rd_req     in   read request; samples rd_addr_a/rd_addr_b
//               rd_addr_a  in   read port A index (rs)
//               rd_addr_b  in   read port B index (rt)
//               rd_data_a  out  registered read data A
//               rd_data_b  out  registered read data B
//               rd_valid   out  one-cycle pulse; rd_data_a/b were updated
//                               by the previous rd_req
// Revision    : 1.0  initial release
// ============================================================================
module reg_bank_rd #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int SP_ADDR = 29,
    parameter int SP_INIT = 227
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_wr,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_valid
);

    localparam int c_nregs = 2 ** ADDR_W;

    // Current contents of every register. Entry 0 is a constant, not a flop.
    logic [DATA_W-1:0] w_regs [c_nregs];

    // A write to index 0 is dropped here once. Each register below then only
    // needs to compare the address.
    logic w_wr_en;
    assign w_wr_en = reg_wr && (wr_addr != '0);

    // ------------------------------------------------------------------------
    // Register storage
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < c_nregs; i++) begin : g_reg
        if (i == 0) begin : g_zero
            assign w_regs[i] = '0;
        end else begin : g_flop
            localparam logic [DATA_W-1:0] c_rst_val =
                (i == SP_ADDR) ? DATA_W'(SP_INIT) : '0;

            logic [DATA_W-1:0] r_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_q <= c_rst_val;
                end else if (w_wr_en && (wr_addr == ADDR_W'(i))) begin
                    r_q <= wr_data;
                end
            end

            assign w_regs[i] = r_q;
        end
    end

    // ------------------------------------------------------------------------
    // Read-port selection
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] w_nxt_a;
    logic [DATA_W-1:0] w_nxt_b;

`ifdef REG_BANK_BYPASS_EN
    // Forward the in-flight write data when it targets the register being
    // read. Index 0 never forwards, because w_wr_en already excludes it.
    logic w_fwd_a;
    logic w_fwd_b;

    assign w_fwd_a = w_wr_en && (wr_addr == rd_addr_a);
    assign w_fwd_b = w_wr_en && (wr_addr == rd_addr_b);
    assign w_nxt_a = w_fwd_a ? wr_data : w_regs[rd_addr_a];
    assign w_nxt_b = w_fwd_b ? wr_data : w_regs[rd_addr_b];
`else
    // No forwarding: a same-cycle write is seen only by later reads.
    assign w_nxt_a = w_regs[rd_addr_a];
    assign w_nxt_b = w_regs[rd_addr_b];
`endif

    // ------------------------------------------------------------------------
    // Output registers. Data holds between requests; valid is a 1-cycle flag.
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] r_rd_data_a;
    logic [DATA_W-1:0] r_rd_data_b;
    logic              r_rd_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data_a <= '0;
            r_rd_data_b <= '0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_rd_valid <= rd_req;
            if (rd_req) begin
                r_rd_data_a <= w_nxt_a;
                r_rd_data_b <= w_nxt_b;
            end
        end
    end

    assign rd_data_a = r_rd_data_a;
    assign rd_data_b = r_rd_data_b;
    assign rd_valid  = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_rd.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bank_rd
// Description : Self-checking bench for reg_bank_rd.
//               - Directed vectors are applied one clock at a time from a
//                 table, each with hand-computed expected outputs.
//               - A hand-written sequence then covers an asynchronous reset
//                 asserted mid-cycle while a read is pending.
// Revision    : 1.0  initial release
// ============================================================================
module tb_reg_bank_rd;

`ifdef REG_BANK_BYPASS_EN
    localparam bit c_bypass = 1'b1;
`else
    localparam bit c_bypass = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        reg_wr;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_req;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic        rd_valid;

    int total;
    int bad;

    reg_bank_rd #(
        .DATA_W  (32),
        .ADDR_W  (5),
        .SP_ADDR (29),
        .SP_INIT (227)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .reg_wr    (reg_wr),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_req    (rd_req),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .rd_valid  (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        req;
        logic [4:0]  a;
        logic [4:0]  b;
        logic        ev;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    localparam int c_nvec = 14;
    vec_t vecs [c_nvec];

    function automatic vec_t mkv(input logic wr, input logic [4:0] wa,
                                 input logic [31:0] wd, input logic req,
                                 input logic [4:0] a, input logic [4:0] b,
                                 input logic ev, input logic [31:0] ea,
                                 input logic [31:0] eb);
        vec_t v;
        v.wr = wr; v.wa = wa; v.wd = wd; v.req = req; v.a = a; v.b = b;
        v.ev = ev; v.ea = ea; v.eb = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic wr, input logic [4:0] wa,
                         input logic [31:0] wd, input logic req,
                         input logic [4:0] a, input logic [4:0] b);
        reg_wr    = wr;
        wr_addr   = wa;
        wr_data   = wd;
        rd_req    = req;
        rd_addr_a = a;
        rd_addr_b = b;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        //            wr  wa     wd            req a      b      ev   ea            eb
        vecs[0]  = mkv(0, 5'd0,  32'h0,        1, 5'd29, 5'd0,  1, 32'd227,      32'h0);
        vecs[1]  = mkv(1, 5'd8,  32'hDEADBEEF, 0, 5'd0,  5'd0,  0, 32'd227,      32'h0);
        vecs[2]  = mkv(0, 5'd0,  32'h0,        1, 5'd8,  5'd8,  1, 32'hDEADBEEF, 32'hDEADBEEF);
        vecs[3]  = mkv(1, 5'd0,  32'hFFFFFFFF, 1, 5'd0,  5'd8,  1, 32'h0,        32'hDEADBEEF);
        vecs[4]  = mkv(0, 5'd0,  32'h0,        1, 5'd0,  5'd0,  1, 32'h0,        32'h0);
        vecs[5]  = mkv(1, 5'd5,  32'h7,        0, 5'd0,  5'd0,  0, 32'h0,        32'h0);
        vecs[6]  = mkv(1, 5'd5,  32'h12,       1, 5'd5,  5'd5,  1,
                       c_bypass ? 32'h12 : 32'h7, c_bypass ? 32'h12 : 32'h7);
        vecs[7]  = mkv(0, 5'd0,  32'h0,        1, 5'd5,  5'd29, 1, 32'h12,       32'd227);
        vecs[8]  = mkv(0, 5'd0,  32'h0,        1, 5'd8,  5'd5,  1, 32'hDEADBEEF, 32'h12);
        vecs[9]  = mkv(0, 5'd0,  32'h0,        0, 5'd1,  5'd2,  0, 32'hDEADBEEF, 32'h12);
        vecs[10] = mkv(0, 5'd0,  32'h0,        0, 5'd3,  5'd4,  0, 32'hDEADBEEF, 32'h12);
        vecs[11] = mkv(0, 5'd0,  32'h0,        0, 5'd6,  5'd7,  0, 32'hDEADBEEF, 32'h12);
        vecs[12] = mkv(1, 5'd29, 32'h100,      1, 5'd29, 5'd31, 1,
                       c_bypass ? 32'h100 : 32'd227, 32'h0);
        vecs[13] = mkv(0, 5'd0,  32'h0,        1, 5'd29, 5'd29, 1, 32'h100,      32'h100);

        // Reset state
        reset = 1'b1;
        drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
        #1;
        check("rst_valid", {31'b0, rd_valid}, 32'h0);
        check("rst_data_a", rd_data_a, 32'h0);
        check("rst_data_b", rd_data_b, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < c_nvec; i++) begin
            @(negedge clk);
            drive(vecs[i].wr, vecs[i].wa, vecs[i].wd, vecs[i].req, vecs[i].a, vecs[i].b);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid", i), {31'b0, rd_valid}, {31'b0, vecs[i].ev});
            check($sformatf("v%0d_data_a", i), rd_data_a, vecs[i].ea);
            check($sformatf("v%0d_data_b", i), rd_data_b, vecs[i].eb);
        end

        // Asynchronous reset mid-cycle with a read pending (r29 is 0x100 here)
        @(negedge clk);
        drive(0, 5'd0, 32'h0, 1, 5'd29, 5'd8);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", {31'b0, rd_valid}, 32'h0);
        check("arst_data_a", rd_data_a, 32'h0);
        check("arst_data_b", rd_data_b, 32'h0);
        @(posedge clk);
        #1;
        check("arst_hold_valid", {31'b0, rd_valid}, 32'h0);
        @(negedge clk);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_no_pulse", {31'b0, rd_valid}, 32'h0);
        check("post_rst_data_a", rd_data_a, 32'h0);
        @(negedge clk);
        drive(0, 5'd0, 32'h0, 1, 5'd29, 5'd8);
        @(posedge clk);
        #1;
        check("post_rst_sp", rd_data_a, 32'd227);
        check("post_rst_r8", rd_data_b, 32'h0);
        check("post_rst_valid", {31'b0, rd_valid}, 32'h1);
        @(negedge clk);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
        @(posedge clk);
        #1;
        check("post_rst_valid_drop", {31'b0, rd_valid}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
